sram_arbiter: RTL

Two-port arbiter and sequencer for the single-read-port instruction/data SRAM. It shares the SRAM between the instruction fetch unit (IF port) and the load/store unit (LS port) with round-robin arbitration. Each granted read is issued to the SRAM with a one-cycle enable pulse, and the registered SRAM output is captured before the SRAM clears it. The result is held in a response buffer until the requester accepts it. It sits between the IFU/LSU and the SRAM, and the SRAM enable, address and data lines connect only to this block.

---
 rtl/sram_arbiter_if.sv | 46 ++++
 rtl/sram_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Request/response and SRAM signal bundle for sram_arbiter.
// The arbiter uses the slave view; requesters and the SRAM model use the master view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_valid_i;
  logic              if_req_ready_o;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_resp_valid_o;
  logic              if_resp_ready_i;
  logic [DATA_W-1:0] if_data_o;

  logic              ls_req_valid_i;
  logic              ls_req_ready_o;
  logic [ADDR_W-1:0] ls_addr_i;
  logic              ls_resp_valid_o;
  logic              ls_resp_ready_i;
  logic [DATA_W-1:0] ls_data_o;

  logic              sram_enable_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] sram_data_i;

  logic              busy_o;

  modport slave (
    input  if_req_valid_i, if_addr_i, if_resp_ready_i,
    output if_req_ready_o, if_resp_valid_o, if_data_o,
    input  ls_req_valid_i, ls_addr_i, ls_resp_ready_i,
    output ls_req_ready_o, ls_resp_valid_o, ls_data_o,
    output sram_enable_o, sram_addr_o,
    input  sram_data_i,
    output busy_o
  );

  modport master (
    output if_req_valid_i, if_addr_i, if_resp_ready_i,
    input  if_req_ready_o, if_resp_valid_o, if_data_o,
    output ls_req_valid_i, ls_addr_i, ls_resp_ready_i,
    input  ls_req_ready_o, ls_resp_valid_o, ls_data_o,
    input  sram_enable_o, sram_addr_o,
    output sram_data_i,
    input  busy_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-read-port SRAM between the IF and LS ports.
// Each transaction is grant (IDLE) -> capture (WAIT) -> hold response (RESP).
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  state_e            state_q, state_d;
  port_e             owner_q, owner_d;
  port_e             last_grant_q, last_grant_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  port_e             grant;
  logic              grant_valid;
  logic              owner_accepts;

  logic              if_req_ready;
  logic              ls_req_ready;
  logic              if_resp_valid;
  logic              ls_resp_valid;
  logic              sram_enable;
  logic [ADDR_W-1:0] sram_addr;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  always_comb begin
    grant_valid = 1'b0;
    grant       = PORT_IF;
    if (bus.if_req_valid_i && bus.ls_req_valid_i) begin
      grant_valid = 1'b1;
      grant       = (last_grant_q == PORT_IF) ? PORT_LS : PORT_IF;
    end else if (bus.if_req_valid_i) begin
      grant_valid = 1'b1;
      grant       = PORT_IF;
    end else if (bus.ls_req_valid_i) begin
      grant_valid = 1'b1;
      grant       = PORT_LS;
    end
  end

  assign owner_accepts = (owner_q == PORT_IF) ? bus.if_resp_ready_i
                                              : bus.ls_resp_ready_i;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    resp_data_d   = resp_data_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    sram_enable   = 1'b0;
    sram_addr     = '0;

    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst_i so the outputs stay quiet while reset is held.
        if (grant_valid && !rst_i) begin
          sram_enable  = 1'b1;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ST_WAIT;
          if (grant == PORT_IF) begin
            if_req_ready = 1'b1;
            sram_addr    = bus.if_addr_i;
          end else begin
            ls_req_ready = 1'b1;
            sram_addr    = bus.ls_addr_i;
          end
        end
      end

      ST_WAIT: begin
        // The SRAM clears its output one cycle after the read, so grab it now.
        resp_data_d = bus.sram_data_i;
        state_d     = ST_RESP;
      end

      ST_RESP: begin
        if_resp_valid = (owner_q == PORT_IF);
        ls_resp_valid = (owner_q == PORT_LS);
        if (owner_accepts) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_IF;
      last_grant_q <= PORT_LS;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.if_req_ready_o  = if_req_ready;
  assign bus.ls_req_ready_o  = ls_req_ready;
  assign bus.if_resp_valid_o = if_resp_valid;
  assign bus.ls_resp_valid_o = ls_resp_valid;
  assign bus.if_data_o       = resp_data_q;
  assign bus.ls_data_o       = resp_data_q;
  assign bus.sram_enable_o   = sram_enable;
  assign bus.sram_addr_o     = sram_addr;
  assign bus.busy_o          = (state_q != ST_IDLE);

endmodule
